axil_wb_bridge: RTL and testbench
=================================

# axil_wb_bridge

Parametrised AXI4-Lite slave to Wishbone classic master bridge. It replaces the fixed 32-bit bridge in front of the crypto cores (MD5, SHA, AES), and every accelerator wrapper instantiates it. Compared with that bridge it adds:
- configurable data width;
- independent AW/W capture;
- fair read/write arbitration;
- Wishbone error propagation as SLVERR;
- an optional bus-hang timeout.

## Interface
Parameters:
- ADDR_WIDTH, 32, AXI and Wishbone address width.
- DATA_WIDTH, 32, data width; only 32 or 64 are legal (elaboration error otherwise).
- TIMEOUT_CYCLES, 255, Wishbone cycles without ack/err before abort; legal range 2..65535.

Ports (SEL_W = DATA_WIDTH/8):
- clk_i  in  1  single clock; the bridge and the Wishbone side share it.
- rst_i  in  1  reset, asynchronous, active-high.
- slave  AXI_LITE.Slave  —  AXI4-Lite slave; interface widths must equal ADDR_WIDTH/DATA_WIDTH.
- wb_adr_o  out  ADDR_WIDTH  byte address.
- wb_dat_o  out  DATA_WIDTH  write data.
- wb_sel_o  out  SEL_W  byte selects.
- wb_we_o  out  1  write enable.
- wb_cyc_o  out  1  cycle.
- wb_stb_o  out  1  strobe.
- wb_dat_i  in  DATA_WIDTH  read data.
- wb_ack_i  in  1  acknowledge.
- wb_err_i  in  1  error.

## Operation
Write capture:
- The AW and W channels are captured independently into one-entry buffers (aw_full, w_full).
- aw_ready = ~aw_full and w_ready = ~w_full; both are forced to 0 while rst_i is high.

Read acceptance:
- ar_ready is high only in IDLE when the read is granted.

FSM states:
- IDLE: arbitrates. A write is eligible when aw_full & w_full; a read is eligible when ar_valid.
  - Both eligible: grant the opposite of last_grant (reset value = write, so the first tie goes to read).
  - Write grant → WB_WR; read grant → WB_RD (ar_addr is latched on the ar handshake).
- WB_WR / WB_RD: drive cyc=stb=1.
  - WB_WR drives we=1, sel=w_strb, dat=w_data.
  - WB_RD drives we=0, sel=all ones.
  - adr = latched address; no low-bit masking.
  - Exit to the response state on wb_ack_i, wb_err_i or timeout.
- B_RESP: b_valid=1, held until b_ready; then clear both write buffers and return to IDLE.
- R_RESP: r_valid=1, r_data = captured wb_dat_i, held until r_ready; then return to IDLE.

Response codes:
- ack only → OKAY (2'b00).
- err (with or without ack in the same cycle) → SLVERR (2'b10).
- Timeout → SLVERR, with r_data = 0.

Other rules:
- wb_dat_i is sampled only in the ack/err cycle.
- Only one Wishbone cycle is outstanding at a time; there is no pipelining.
- An ack or err arriving while cyc=0 is ignored.
- Reset mid-operation: cyc/stb drop asynchronously, buffers and FSM clear, and any pending response is discarded.

## Timing
Reset values:
- wb_cyc_o, wb_stb_o, wb_we_o = 0; wb_adr_o, wb_dat_o, wb_sel_o = 0.
- b_valid, r_valid, ar_ready = 0; b_resp, r_resp, r_data = 0.
- aw_ready = w_ready = 1 from the first cycle after deassert.

Latency (cycle N = handshake completing the pair or the read):
- WB cycle asserted at N+1.
- ack at cycle M → b_valid or r_valid at M+1; cyc low at M+1.
- Minimum AXI write or read turnaround with a zero-wait slave is 3 cycles.

Arbitration and buffers:
- last_grant updates on every grant.
- A new AW/W pair may be captured during B_RESP only after the buffers clear.

## Configuration
AXIL_WB_TIMEOUT_EN defined:
- A counter runs while cyc=1 and clears when cyc=0.
- When it reaches TIMEOUT_CYCLES-1 with no ack/err, the next cycle drops cyc and goes to the response state with SLVERR.

AXIL_WB_TIMEOUT_EN undefined:
- The counter is absent; the bridge waits indefinitely for ack/err.
- TIMEOUT_CYCLES is unused.

## Structure
- Package axil_wb_pkg holds:
  - the resp_t codes RESP_OKAY = 2'b00 and RESP_SLVERR = 2'b10;
  - the FSM enum state_t {IDLE, WB_WR, WB_RD, B_RESP, R_RESP};
  - the TIMEOUT_W function, clog2(TIMEOUT_CYCLES+1).
- Sub-module axil_wb_timeout holds the counter, the expire flag and the clear logic. It is instantiated only under AXIL_WB_TIMEOUT_EN.

## Test plan
- Write: W beat (data 0x12345678, strb 0xF) one cycle before AW (addr 0x40), slave acks after 2 waits → WB shows adr 0x40, sel 0xF, we=1; b_resp=OKAY; b_valid one cycle after ack.
- Read: addr 0x44, slave returns 0xCAFEF00D with ack → r_data=0xCAFEF00D, r_resp=OKAY; with r_ready held low 5 cycles, r_valid and r_data stay stable.
- Arbitration: write pair and read presented in the same cycle, twice in a row → first grant read, second grant write; no WB cycles overlap.
- Error: wb_err_i and wb_ack_i together on a write with strb 0x3 → sel=0x3, b_resp=SLVERR.
- Timeout (macro defined, TIMEOUT_CYCLES=16): slave never responds to a read → cyc held exactly 16 cycles, then r_resp=SLVERR, r_data=0; a late ack is ignored. With the macro undefined, cyc stays high for 1000 cycles.
- Reset mid-cycle: rst_i asserted while cyc=1 → cyc/stb low in the same cycle, no b_valid/r_valid after release, and the next write completes normally.

Source files
------------

// File: rtl/axil_wb_pkg.sv
// Shared types and helpers for the AXI4-Lite to Wishbone classic bridge.
// Optional feature macro: AXIL_WB_TIMEOUT_EN (Wishbone bus-hang timeout).
package axil_wb_pkg;

  // AXI response codes produced by the bridge.
  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_t;

  // Bridge control states.
  typedef enum logic [2:0] {
    IDLE,
    WB_WR,
    WB_RD,
    B_RESP,
    R_RESP
  } state_t;

  // Legal bounds for the timeout length.
  localparam int unsigned TIMEOUT_MIN = 2;
  localparam int unsigned TIMEOUT_MAX = 65535;

  // Width of a counter able to hold 0..timeout_cycles.
  function automatic int unsigned TIMEOUT_W(input int unsigned timeout_cycles);
    return $clog2(timeout_cycles + 1);
  endfunction

endpackage

// File: rtl/axi_lite_if.sv
// AXI4-Lite bundle with slave and master views.
interface AXI_LITE #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0]   aw_addr;
  logic                    aw_valid;
  logic                    aw_ready;

  logic [DATA_WIDTH-1:0]   w_data;
  logic [DATA_WIDTH/8-1:0] w_strb;
  logic                    w_valid;
  logic                    w_ready;

  logic [1:0]              b_resp;
  logic                    b_valid;
  logic                    b_ready;

  logic [ADDR_WIDTH-1:0]   ar_addr;
  logic                    ar_valid;
  logic                    ar_ready;

  logic [DATA_WIDTH-1:0]   r_data;
  logic [1:0]              r_resp;
  logic                    r_valid;
  logic                    r_ready;

  modport Slave (
    input  aw_addr, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_valid,
    output w_ready,
    output b_resp, b_valid,
    input  b_ready,
    input  ar_addr, ar_valid,
    output ar_ready,
    output r_data, r_resp, r_valid,
    input  r_ready
  );

  modport Master (
    output aw_addr, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_valid,
    input  w_ready,
    input  b_resp, b_valid,
    output b_ready,
    output ar_addr, ar_valid,
    input  ar_ready,
    input  r_data, r_resp, r_valid,
    output r_ready
  );

endinterface

// File: rtl/axil_wb_timeout.sv
// Wishbone bus-hang watchdog: counts cycles spent with cyc high and flags
// expiry on the last allowed cycle. Used only when AXIL_WB_TIMEOUT_EN is set.
module axil_wb_timeout
  import axil_wb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic cyc,
  output logic expire
);

  localparam int unsigned    CNT_W = TIMEOUT_W(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  // Expiry is seen during the final allowed cycle so the bridge drops cyc
  // on the next edge, giving exactly TIMEOUT_CYCLES cycles of cyc high.
  assign expire = cyc & (count == LAST);

  // Count while a Wishbone cycle is open; restart whenever cyc is low.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count <= '0;
    end else if (!cyc) begin
      count <= '0;
    end else if (!expire) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/axil_wb_bridge.sv
// AXI4-Lite slave to Wishbone classic master bridge.
// Independent one-entry AW/W buffers, fair read/write arbitration, Wishbone
// err mapped to SLVERR. Optional bus-hang timeout enabled by defining
// AXIL_WB_TIMEOUT_EN; without it the bridge waits indefinitely for ack/err.
module axil_wb_bridge
  import axil_wb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  AXI_LITE.Slave                  slave,
  output logic [ADDR_WIDTH-1:0]   wb_adr_o,
  output logic [DATA_WIDTH-1:0]   wb_dat_o,
  output logic [DATA_WIDTH/8-1:0] wb_sel_o,
  output logic                    wb_we_o,
  output logic                    wb_cyc_o,
  output logic                    wb_stb_o,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  input  logic                    wb_ack_i,
  input  logic                    wb_err_i
);

  localparam int unsigned SEL_W = DATA_WIDTH / 8;

  // Elaboration-time legality checks.
  if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_data_width
    $error("axil_wb_bridge: DATA_WIDTH must be 32 or 64");
  end
  if (TIMEOUT_CYCLES < TIMEOUT_MIN || TIMEOUT_CYCLES > TIMEOUT_MAX) begin : g_bad_timeout
    $error("axil_wb_bridge: TIMEOUT_CYCLES must be within 2..65535");
  end
  if ($bits(slave.aw_addr) != ADDR_WIDTH || $bits(slave.w_data) != DATA_WIDTH) begin : g_bad_if
    $error("axil_wb_bridge: AXI_LITE widths must match ADDR_WIDTH/DATA_WIDTH");
  end

  state_t                  state;
  logic                    last_wr;     // 1: last grant went to the write side

  logic                    aw_full;
  logic [ADDR_WIDTH-1:0]   aw_addr_q;
  logic                    w_full;
  logic [DATA_WIDTH-1:0]   w_data_q;
  logic [SEL_W-1:0]        w_strb_q;

  logic                    b_valid_q;
  resp_t                   b_resp_q;
  logic                    r_valid_q;
  resp_t                   r_resp_q;
  logic [DATA_WIDTH-1:0]   r_data_q;

  logic                    aw_ready;
  logic                    w_ready;
  logic                    aw_fire;
  logic                    w_fire;
  logic                    wr_eligible;
  logic                    grant_wr;
  logic                    grant_rd;
  logic                    buf_clear;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic [SEL_W-1:0]        wr_strb;
  logic                    wb_done;
  logic                    wb_answered;
  resp_t                   done_resp;
  logic                    expire;

`ifdef AXIL_WB_TIMEOUT_EN
  axil_wb_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .cyc    (wb_cyc_o),
    .expire (expire)
  );
`else
  assign expire = 1'b0;
`endif

  // Buffer readiness is held low during reset so nothing is accepted then.
  assign aw_ready = ~aw_full & ~rst_i;
  assign w_ready  = ~w_full & ~rst_i;
  assign aw_fire  = slave.aw_valid & aw_ready;
  assign w_fire   = slave.w_valid & w_ready;

  // A beat arriving in this cycle counts as buffered so a completed pair can
  // be launched on the same edge that captures it.
  assign wr_eligible = (aw_full | aw_fire) & (w_full | w_fire);
  assign wr_addr     = aw_full ? aw_addr_q : slave.aw_addr;
  assign wr_data     = w_full ? w_data_q : slave.w_data;
  assign wr_strb     = w_full ? w_strb_q : slave.w_strb;

  // Write buffers empty once the write response is taken.
  assign buf_clear = (state == B_RESP) & slave.b_ready;

  // Termination of the current Wishbone cycle; ack/err win over timeout.
  assign wb_answered = wb_ack_i | wb_err_i;
  assign wb_done     = wb_answered | expire;
  assign done_resp   = (wb_ack_i & ~wb_err_i) ? RESP_OKAY : RESP_SLVERR;

  // Arbitration in IDLE: on a tie, grant the side not served last time.
  // NOTE: every output of an always_comb gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    grant_wr = 1'b0;
    grant_rd = 1'b0;
    if (state == IDLE && !rst_i) begin
      if (wr_eligible && (!slave.ar_valid || !last_wr)) begin
        grant_wr = 1'b1;
      end else if (slave.ar_valid) begin
        grant_rd = 1'b1;
      end
    end
  end

  assign slave.aw_ready = aw_ready;
  assign slave.w_ready  = w_ready;
  assign slave.ar_ready = grant_rd;
  assign slave.b_valid  = b_valid_q;
  assign slave.b_resp   = b_resp_q;
  assign slave.r_valid  = r_valid_q;
  assign slave.r_resp   = r_resp_q;
  assign slave.r_data   = r_data_q;

  // Occupancy flags of the AW and W buffers.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      aw_full <= 1'b0;
      w_full  <= 1'b0;
    end else begin
      if (aw_fire) begin
        aw_full <= 1'b1;
      end else if (buf_clear) begin
        aw_full <= 1'b0;
      end
      if (w_fire) begin
        w_full <= 1'b1;
      end else if (buf_clear) begin
        w_full <= 1'b0;
      end
    end
  end

  // Buffer payloads, loaded on each accepted beat.
  // NOTE: payload registers carry no reset; the full flags qualify them, so
  // their power-up contents are never observed.
  always_ff @(posedge clk_i) begin
    if (aw_fire) begin
      aw_addr_q <= slave.aw_addr;
    end
    if (w_fire) begin
      w_data_q <= slave.w_data;
      w_strb_q <= slave.w_strb;
    end
  end

  // Main control FSM with registered Wishbone and AXI response outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      last_wr   <= 1'b1;
      wb_cyc_o  <= 1'b0;
      wb_stb_o  <= 1'b0;
      wb_we_o   <= 1'b0;
      wb_adr_o  <= '0;
      wb_dat_o  <= '0;
      wb_sel_o  <= '0;
      b_valid_q <= 1'b0;
      b_resp_q  <= RESP_OKAY;
      r_valid_q <= 1'b0;
      r_resp_q  <= RESP_OKAY;
      r_data_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_wr) begin
            state    <= WB_WR;
            last_wr  <= 1'b1;
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            wb_we_o  <= 1'b1;
            wb_adr_o <= wr_addr;
            wb_dat_o <= wr_data;
            wb_sel_o <= wr_strb;
          end else if (grant_rd) begin
            state    <= WB_RD;
            last_wr  <= 1'b0;
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            wb_we_o  <= 1'b0;
            wb_adr_o <= slave.ar_addr;
            wb_sel_o <= '1;
          end
        end

        WB_WR: begin
          if (wb_done) begin
            state     <= B_RESP;
            wb_cyc_o  <= 1'b0;
            wb_stb_o  <= 1'b0;
            wb_we_o   <= 1'b0;
            b_valid_q <= 1'b1;
            b_resp_q  <= done_resp;
          end
        end

        WB_RD: begin
          if (wb_done) begin
            state     <= R_RESP;
            wb_cyc_o  <= 1'b0;
            wb_stb_o  <= 1'b0;
            r_valid_q <= 1'b1;
            r_resp_q  <= done_resp;
            r_data_q  <= wb_answered ? wb_dat_i : '0;
          end
        end

        B_RESP: begin
          if (slave.b_ready) begin
            state     <= IDLE;
            b_valid_q <= 1'b0;
          end
        end

        R_RESP: begin
          if (slave.r_ready) begin
            state     <= IDLE;
            r_valid_q <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axil_wb_bridge.sv
// Directed self-checking bench for axil_wb_bridge (32-bit, TIMEOUT_CYCLES=16).
// Covers reset, write/read paths, arbitration, error mapping, timeout (both
// builds of AXIL_WB_TIMEOUT_EN) and reset during an open Wishbone cycle.
module tb_axil_wb_bridge;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] wb_adr;
  logic [DW-1:0] wb_dat_o;
  logic [DW-1:0] wb_dat_i;
  logic [3:0]    wb_sel;
  logic          wb_we;
  logic          wb_cyc;
  logic          wb_stb;
  logic          wb_ack;
  logic          wb_err;

  int checks = 0;
  int errors = 0;

  AXI_LITE #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

  axil_wb_bridge #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .slave    (axi),
    .wb_adr_o (wb_adr),
    .wb_dat_o (wb_dat_o),
    .wb_sel_o (wb_sel),
    .wb_we_o  (wb_we),
    .wb_cyc_o (wb_cyc),
    .wb_stb_o (wb_stb),
    .wb_dat_i (wb_dat_i),
    .wb_ack_i (wb_ack),
    .wb_err_i (wb_err)
  );

  always #5 clk = ~clk;

  // Advance n rising edges and settle 1 ns past the last one.
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    axi.aw_valid = 1'b0; axi.aw_addr = '0;
    axi.w_valid  = 1'b0; axi.w_data  = '0; axi.w_strb = '0;
    axi.b_ready  = 1'b0;
    axi.ar_valid = 1'b0; axi.ar_addr = '0;
    axi.r_ready  = 1'b0;
    wb_dat_i = '0; wb_ack = 1'b0; wb_err = 1'b0;

    // ---- reset state ----
    step(2);
    check("rst_aw_ready", axi.aw_ready, 0);
    check("rst_w_ready", axi.w_ready, 0);
    check("rst_ar_ready", axi.ar_ready, 0);
    check("rst_cyc", wb_cyc, 0);
    check("rst_stb", wb_stb, 0);
    check("rst_we", wb_we, 0);
    check("rst_adr", wb_adr, 0);
    check("rst_dat", wb_dat_o, 0);
    check("rst_sel", wb_sel, 0);
    check("rst_b_valid", axi.b_valid, 0);
    check("rst_r_valid", axi.r_valid, 0);
    check("rst_b_resp", axi.b_resp, 0);
    check("rst_r_resp", axi.r_resp, 0);
    check("rst_r_data", axi.r_data, 0);
    rst = 1'b0;
    #1;
    check("post_rst_aw_ready", axi.aw_ready, 1);
    check("post_rst_w_ready", axi.w_ready, 1);

    // ---- arbitration: tie goes to read first (reset last grant = write) ----
    axi.aw_valid = 1'b1; axi.aw_addr = 32'h80;
    axi.w_valid  = 1'b1; axi.w_data  = 32'hA5A5A5A5; axi.w_strb = 4'hF;
    axi.ar_valid = 1'b1; axi.ar_addr = 32'h84;
    #1;
    check("arb1_ar_ready", axi.ar_ready, 1);
    step();
    axi.aw_valid = 1'b0; axi.w_valid = 1'b0; axi.ar_valid = 1'b0;
    check("arb1_cyc", wb_cyc, 1);
    check("arb1_we", wb_we, 0);
    check("arb1_adr", wb_adr, 32'h84);
    check("arb1_aw_buffered", axi.aw_ready, 0);
    check("arb1_w_buffered", axi.w_ready, 0);
    wb_dat_i = 32'h0BADCAFE; wb_ack = 1'b1;
    step();
    wb_ack = 1'b0;
    check("arb1_r_valid", axi.r_valid, 1);
    check("arb1_r_data", axi.r_data, 32'h0BADCAFE);
    check("arb1_cyc_low", wb_cyc, 0);
    // second tie: pending write pair versus a new read -> write wins
    axi.r_ready = 1'b1; axi.ar_valid = 1'b1; axi.ar_addr = 32'h88;
    #1;
    check("arb2_ar_ready_in_rresp", axi.ar_ready, 0);
    step();
    axi.r_ready = 1'b0;
    #1;
    check("arb2_ar_ready_tie", axi.ar_ready, 0);
    check("arb2_no_overlap", wb_cyc, 0);
    step();
    check("arb2_cyc", wb_cyc, 1);
    check("arb2_we", wb_we, 1);
    check("arb2_adr", wb_adr, 32'h80);
    check("arb2_dat", wb_dat_o, 32'hA5A5A5A5);
    wb_ack = 1'b1;
    step();
    wb_ack = 1'b0;
    check("arb2_b_valid", axi.b_valid, 1);
    check("arb2_b_resp", axi.b_resp, 2'b00);
    check("arb2_ar_ready_in_bresp", axi.ar_ready, 0);
    axi.b_ready = 1'b1;
    step();
    axi.b_ready = 1'b0;
    #1;
    check("arb3_ar_ready", axi.ar_ready, 1);
    step();
    axi.ar_valid = 1'b0;
    check("arb3_adr", wb_adr, 32'h88);
    check("arb3_we", wb_we, 0);
    wb_dat_i = 32'h11112222; wb_ack = 1'b1;
    step();
    wb_ack = 1'b0;
    check("arb3_r_data", axi.r_data, 32'h11112222);
    axi.r_ready = 1'b1;
    step();
    axi.r_ready = 1'b0;
    check("arb3_r_valid_done", axi.r_valid, 0);

    // ---- write: W one cycle before AW, slave acks after 2 wait cycles ----
    axi.w_valid = 1'b1; axi.w_data = 32'h12345678; axi.w_strb = 4'hF;
    #1;
    check("wr_w_ready", axi.w_ready, 1);
    step();
    axi.w_valid = 1'b0;
    axi.aw_valid = 1'b1; axi.aw_addr = 32'h40;
    #1;
    check("wr_w_full", axi.w_ready, 0);
    check("wr_aw_ready", axi.aw_ready, 1);
    check("wr_cyc_before_pair", wb_cyc, 0);
    step();
    axi.aw_valid = 1'b0;
    check("wr_cyc_n1", wb_cyc, 1);
    check("wr_stb", wb_stb, 1);
    check("wr_we", wb_we, 1);
    check("wr_adr", wb_adr, 32'h40);
    check("wr_sel", wb_sel, 4'hF);
    check("wr_dat", wb_dat_o, 32'h12345678);
    step(2);
    check("wr_wait_b_valid", axi.b_valid, 0);
    check("wr_wait_cyc", wb_cyc, 1);
    wb_ack = 1'b1;
    step();
    wb_ack = 1'b0;
    check("wr_b_valid", axi.b_valid, 1);
    check("wr_b_resp", axi.b_resp, 2'b00);
    check("wr_cyc_after_ack", wb_cyc, 0);
    check("wr_stb_after_ack", wb_stb, 0);
    axi.b_ready = 1'b1;
    step();
    axi.b_ready = 1'b0;
    check("wr_b_done", axi.b_valid, 0);
    check("wr_aw_ready_cleared", axi.aw_ready, 1);

    // ---- read: r_ready held low for 5 cycles ----
    axi.ar_valid = 1'b1; axi.ar_addr = 32'h44;
    #1;
    check("rd_ar_ready", axi.ar_ready, 1);
    step();
    axi.ar_valid = 1'b0;
    check("rd_cyc", wb_cyc, 1);
    check("rd_we", wb_we, 0);
    check("rd_adr", wb_adr, 32'h44);
    check("rd_sel", wb_sel, 4'hF);
    wb_dat_i = 32'hCAFEF00D; wb_ack = 1'b1;
    step();
    wb_ack = 1'b0; wb_dat_i = 32'hDEADBEEF;
    check("rd_r_valid", axi.r_valid, 1);
    check("rd_r_data", axi.r_data, 32'hCAFEF00D);
    check("rd_r_resp", axi.r_resp, 2'b00);
    check("rd_cyc_after_ack", wb_cyc, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      check("rd_hold_valid", axi.r_valid, 1);
      check("rd_hold_data", axi.r_data, 32'hCAFEF00D);
    end
    axi.r_ready = 1'b1;
    step();
    axi.r_ready = 1'b0;
    check("rd_done", axi.r_valid, 0);

    // ---- error: err and ack together on a write with strb 0x3 ----
    axi.aw_valid = 1'b1; axi.aw_addr = 32'h50;
    axi.w_valid  = 1'b1; axi.w_data  = 32'h0000BEEF; axi.w_strb = 4'h3;
    step();
    axi.aw_valid = 1'b0; axi.w_valid = 1'b0;
    check("err_cyc", wb_cyc, 1);
    check("err_sel", wb_sel, 4'h3);
    check("err_adr", wb_adr, 32'h50);
    wb_ack = 1'b1; wb_err = 1'b1;
    step();
    wb_ack = 1'b0; wb_err = 1'b0;
    check("err_b_valid", axi.b_valid, 1);
    check("err_b_resp", axi.b_resp, 2'b10);
    axi.b_ready = 1'b1;
    step();
    axi.b_ready = 1'b0;

    // ---- timeout: slave never answers a read ----
    wb_dat_i = 32'h55AA55AA;
    axi.ar_valid = 1'b1; axi.ar_addr = 32'h60;
    step();
    axi.ar_valid = 1'b0;
    check("to_cyc", wb_cyc, 1);
`ifdef AXIL_WB_TIMEOUT_EN
    n = 0;
    while (wb_cyc === 1'b1 && n < 100) begin
      n++;
      step();
    end
    check("to_cyc_len", n, 16);
    check("to_r_valid", axi.r_valid, 1);
    check("to_r_resp", axi.r_resp, 2'b10);
    check("to_r_data", axi.r_data, 0);
    wb_ack = 1'b1;
    step();
    wb_ack = 1'b0;
    check("to_late_ack_cyc", wb_cyc, 0);
    check("to_late_ack_r_data", axi.r_data, 0);
    check("to_late_ack_r_resp", axi.r_resp, 2'b10);
`else
    n = 0;
    step(1000);
    check("no_to_cyc_held", wb_cyc, 1);
    check("no_to_r_valid", axi.r_valid, 0);
    wb_dat_i = 32'h00000077; wb_ack = 1'b1;
    step();
    wb_ack = 1'b0;
    check("no_to_r_data", axi.r_data, 32'h77);
    check("no_to_r_resp", axi.r_resp, 2'b00);
`endif
    axi.r_ready = 1'b1;
    step();
    axi.r_ready = 1'b0;
    check("to_done", axi.r_valid, 0);

    // ---- reset while a Wishbone cycle is open ----
    axi.aw_valid = 1'b1; axi.aw_addr = 32'h70;
    axi.w_valid  = 1'b1; axi.w_data  = 32'h01020304; axi.w_strb = 4'hF;
    step();
    axi.aw_valid = 1'b0; axi.w_valid = 1'b0;
    check("mid_rst_cyc_before", wb_cyc, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_cyc", wb_cyc, 0);
    check("mid_rst_stb", wb_stb, 0);
    step(2);
    check("mid_rst_aw_ready", axi.aw_ready, 0);
    rst = 1'b0;
    wb_ack = 1'b1;
    step();
    wb_ack = 1'b0;
    check("mid_rst_b_valid", axi.b_valid, 0);
    check("mid_rst_r_valid", axi.r_valid, 0);
    check("mid_rst_stray_ack_cyc", wb_cyc, 0);
    check("mid_rst_aw_ready_after", axi.aw_ready, 1);
    step(2);
    check("mid_rst_b_valid_late", axi.b_valid, 0);
    axi.aw_valid = 1'b1; axi.aw_addr = 32'h74;
    axi.w_valid  = 1'b1; axi.w_data  = 32'hFEEDFACE; axi.w_strb = 4'hC;
    step();
    axi.aw_valid = 1'b0; axi.w_valid = 1'b0;
    check("post_rst_wr_cyc", wb_cyc, 1);
    check("post_rst_wr_adr", wb_adr, 32'h74);
    check("post_rst_wr_dat", wb_dat_o, 32'hFEEDFACE);
    check("post_rst_wr_sel", wb_sel, 4'hC);
    wb_ack = 1'b1;
    step();
    wb_ack = 1'b0;
    check("post_rst_wr_b_valid", axi.b_valid, 1);
    check("post_rst_wr_b_resp", axi.b_resp, 2'b00);
    axi.b_ready = 1'b1;
    step();
    axi.b_ready = 1'b0;
    check("post_rst_wr_done", axi.b_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
